// File: rtl/label_vote_filter_pkg.sv
// Shared widths, default window depth and enumerations for the label vote filter.
package label_vote_filter_pkg;

  localparam int unsigned DEFAULT_LABEL_WIDTH    = 1;
  localparam int unsigned DEFAULT_DISTANCE_WIDTH = 10;
  localparam int unsigned DEFAULT_WINDOW         = 5;
  localparam int unsigned DEFAULT_CNT_WIDTH      = 4;

  localparam int unsigned NUM_STREAMS = 2;

  typedef enum logic {
    STREAM_A = 1'b0,
    STREAM_V = 1'b1
  } stream_e;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/label_vote_filter_if.sv
// Sample-in / result-out handshake bundle between upstream AM, the filter and the host readout.
interface label_vote_filter_if
  import label_vote_filter_pkg::*;
#(
  parameter int unsigned LABEL_WIDTH    = DEFAULT_LABEL_WIDTH,
  parameter int unsigned DISTANCE_WIDTH = DEFAULT_DISTANCE_WIDTH,
  parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) ();

  logic                                ValidIn_SI;
  logic                                ReadyOut_SO;
  logic [LABEL_WIDTH-1:0]              LabelIn_A_DI;
  logic [LABEL_WIDTH-1:0]              LabelIn_V_DI;
  logic [DISTANCE_WIDTH-1:0]           DistanceIn_A_DI;
  logic [DISTANCE_WIDTH-1:0]           DistanceIn_V_DI;
  logic                                ValidOut_SO;
  logic                                ReadyIn_SI;
  logic [LABEL_WIDTH-1:0]              LabelOut_A_DO;
  logic [LABEL_WIDTH-1:0]              LabelOut_V_DO;
  logic [DISTANCE_WIDTH+CNT_WIDTH-1:0] DistSumOut_A_DO;
  logic [DISTANCE_WIDTH+CNT_WIDTH-1:0] DistSumOut_V_DO;

  modport master (
    output ValidIn_SI, LabelIn_A_DI, LabelIn_V_DI, DistanceIn_A_DI, DistanceIn_V_DI, ReadyIn_SI,
    input  ReadyOut_SO, ValidOut_SO, LabelOut_A_DO, LabelOut_V_DO, DistSumOut_A_DO, DistSumOut_V_DO
  );

  modport slave (
    input  ValidIn_SI, LabelIn_A_DI, LabelIn_V_DI, DistanceIn_A_DI, DistanceIn_V_DI, ReadyIn_SI,
    output ReadyOut_SO, ValidOut_SO, LabelOut_A_DO, LabelOut_V_DO, DistSumOut_A_DO, DistSumOut_V_DO
  );

endinterface

// File: rtl/label_vote_filter_vote_window.sv
// One label stream: circular {label, distance} history, per-class counters, distance sum and argmax vote.
module label_vote_filter_vote_window
  import label_vote_filter_pkg::*;
#(
  parameter int unsigned LABEL_WIDTH    = DEFAULT_LABEL_WIDTH,
  parameter int unsigned DISTANCE_WIDTH = DEFAULT_DISTANCE_WIDTH,
  parameter int unsigned WINDOW         = DEFAULT_WINDOW,
  parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                push_i,
  input  logic                                evict_i,
  input  logic [LABEL_WIDTH-1:0]              label_i,
  input  logic [DISTANCE_WIDTH-1:0]           dist_i,
  output logic [LABEL_WIDTH-1:0]              vote_o,
  output logic [DISTANCE_WIDTH+CNT_WIDTH-1:0] sum_o
);

  localparam int unsigned NCLASS    = 2 ** LABEL_WIDTH;
  localparam int unsigned PTR_WIDTH = $clog2(WINDOW);
  localparam int unsigned SUM_WIDTH = DISTANCE_WIDTH + CNT_WIDTH;

  if ((2 ** CNT_WIDTH) <= WINDOW) begin : g_bad_cnt_width
    $error("CNT_WIDTH too small to count WINDOW samples");
  end
  if ((WINDOW % 2) == 0 || WINDOW < 3 || WINDOW > 15) begin : g_bad_window
    $error("WINDOW must be odd and within 3..15");
  end

  logic [LABEL_WIDTH-1:0]    hist_label_q [WINDOW];
  logic [DISTANCE_WIDTH-1:0] hist_dist_q  [WINDOW];
  logic [CNT_WIDTH-1:0]      cnt_q        [NCLASS];
  logic [CNT_WIDTH-1:0]      cnt_d        [NCLASS];
  logic [SUM_WIDTH-1:0]      sum_q, sum_d;
  logic [PTR_WIDTH-1:0]      wptr_q, wptr_d;
  logic [LABEL_WIDTH-1:0]    old_label;
  logic [DISTANCE_WIDTH-1:0] old_dist;
  logic [CNT_WIDTH-1:0]      best_cnt;

  // Once the window is full the write slot always holds the oldest entry.
  assign old_label = hist_label_q[wptr_q];
  assign old_dist  = hist_dist_q[wptr_q];
  assign sum_o     = sum_q;

  always_comb begin
    wptr_d = wptr_q;
    sum_d  = sum_q;
    for (int unsigned c = 0; c < NCLASS; c++) begin
      cnt_d[c] = cnt_q[c];
    end
    if (push_i) begin
      wptr_d = (wptr_q == PTR_WIDTH'(WINDOW - 1)) ? '0 : wptr_q + PTR_WIDTH'(1);
      sum_d  = sum_q + SUM_WIDTH'(dist_i) - (evict_i ? SUM_WIDTH'(old_dist) : '0);
      for (int unsigned c = 0; c < NCLASS; c++) begin
        cnt_d[c] = cnt_q[c] + CNT_WIDTH'(label_i == LABEL_WIDTH'(c))
                            - CNT_WIDTH'(evict_i && (old_label == LABEL_WIDTH'(c)));
      end
    end
  end

  // Strict greater-than keeps the lowest class index on ties.
  always_comb begin
    best_cnt = cnt_q[0];
    vote_o   = '0;
    for (int unsigned c = 1; c < NCLASS; c++) begin
      if (cnt_q[c] > best_cnt) begin
        best_cnt = cnt_q[c];
        vote_o   = LABEL_WIDTH'(c);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr_q <= '0;
      sum_q  <= '0;
      for (int unsigned i = 0; i < WINDOW; i++) begin
        hist_label_q[i] <= '0;
        hist_dist_q[i]  <= '0;
      end
      for (int unsigned c = 0; c < NCLASS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      sum_q  <= sum_d;
      for (int unsigned c = 0; c < NCLASS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      if (push_i) begin
        hist_label_q[wptr_q] <= label_i;
        hist_dist_q[wptr_q]  <= dist_i;
      end
    end
  end

endmodule

// File: rtl/label_vote_filter.sv
// Sliding-window majority vote on A/V labels with windowed distance sums, FILL/RUN FSM and output handshake.
module label_vote_filter
  import label_vote_filter_pkg::*;
#(
  parameter int unsigned LABEL_WIDTH    = DEFAULT_LABEL_WIDTH,
  parameter int unsigned DISTANCE_WIDTH = DEFAULT_DISTANCE_WIDTH,
  parameter int unsigned WINDOW         = DEFAULT_WINDOW,
  parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic               Clk_CI,
  input  logic               Reset_RI,
  input  logic               Flush_SI,
  label_vote_filter_if.slave bus
);

  localparam int unsigned SUM_WIDTH = DISTANCE_WIDTH + CNT_WIDTH;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   fill_q, fill_d;
  logic                   pend_q, pend_d;
  logic                   valid_q, valid_d;
  logic [LABEL_WIDTH-1:0] out_lab_q [NUM_STREAMS];
  logic [LABEL_WIDTH-1:0] out_lab_d [NUM_STREAMS];
  logic [SUM_WIDTH-1:0]   out_sum_q [NUM_STREAMS];
  logic [SUM_WIDTH-1:0]   out_sum_d [NUM_STREAMS];

  logic [LABEL_WIDTH-1:0]    lab_in  [NUM_STREAMS];
  logic [DISTANCE_WIDTH-1:0] dist_in [NUM_STREAMS];
  logic [LABEL_WIDTH-1:0]    vote    [NUM_STREAMS];
  logic [SUM_WIDTH-1:0]      wsum    [NUM_STREAMS];

  logic ready;
  logic accept;
  logic load;

  assign lab_in[STREAM_A]  = bus.LabelIn_A_DI;
  assign lab_in[STREAM_V]  = bus.LabelIn_V_DI;
  assign dist_in[STREAM_A] = bus.DistanceIn_A_DI;
  assign dist_in[STREAM_V] = bus.DistanceIn_V_DI;

  // Flush forces ready low so a same-cycle sample is dropped, not half-applied.
  assign ready  = ~pend_q & (~valid_q | bus.ReadyIn_SI) & ~Flush_SI;
  assign accept = bus.ValidIn_SI & ready;
  assign load   = pend_q & (state_q == RUN) & ~Flush_SI;

  for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_stream
    label_vote_filter_vote_window #(
      .LABEL_WIDTH    (LABEL_WIDTH),
      .DISTANCE_WIDTH (DISTANCE_WIDTH),
      .WINDOW         (WINDOW),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_win (
      .clk_i   (Clk_CI),
      .rst_i   (Reset_RI),
      .clear_i (Flush_SI),
      .push_i  (accept),
      .evict_i (state_q == RUN),
      .label_i (lab_in[s]),
      .dist_i  (dist_in[s]),
      .vote_o  (vote[s]),
      .sum_o   (wsum[s])
    );
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    pend_d  = 1'b0;
    valid_d = valid_q;
    for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
      out_lab_d[s] = out_lab_q[s];
      out_sum_d[s] = out_sum_q[s];
    end

    if (Flush_SI) begin
      state_d = FILL;
      fill_d  = '0;
    end else if (accept) begin
      pend_d = 1'b1;
      if (state_q == FILL) begin
        fill_d = fill_q + CNT_WIDTH'(1);
        if (fill_q == CNT_WIDTH'(WINDOW - 1)) begin
          state_d = RUN;
        end
      end
    end

    if (load) begin
      valid_d = 1'b1;
      for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
        out_lab_d[s] = vote[s];
        out_sum_d[s] = wsum[s];
      end
    end else if (bus.ReadyIn_SI) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q <= FILL;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
        out_lab_q[s] <= '0;
        out_sum_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
        out_lab_q[s] <= out_lab_d[s];
        out_sum_q[s] <= out_sum_d[s];
      end
    end
  end

  assign bus.ReadyOut_SO     = ready;
  assign bus.ValidOut_SO     = valid_q;
  assign bus.LabelOut_A_DO   = out_lab_q[STREAM_A];
  assign bus.LabelOut_V_DO   = out_lab_q[STREAM_V];
  assign bus.DistSumOut_A_DO = out_sum_q[STREAM_A];
  assign bus.DistSumOut_V_DO = out_sum_q[STREAM_V];

endmodule

// File: tb/tb_label_vote_filter.sv
// Directed bench for label_vote_filter: fill, steady state, backpressure, flush, tie-break and reset-while-pending.
module tb_label_vote_filter;

  logic clk;
  logic rst;
  logic flush;
  int   tests;
  int   fails;

  label_vote_filter_if #(.LABEL_WIDTH(1), .DISTANCE_WIDTH(10), .CNT_WIDTH(4)) bus  ();
  label_vote_filter_if #(.LABEL_WIDTH(2), .DISTANCE_WIDTH(10), .CNT_WIDTH(4)) bus2 ();

  label_vote_filter #(
    .LABEL_WIDTH(1), .DISTANCE_WIDTH(10), .WINDOW(5), .CNT_WIDTH(4)
  ) dut (
    .Clk_CI(clk), .Reset_RI(rst), .Flush_SI(flush), .bus(bus)
  );

  label_vote_filter #(
    .LABEL_WIDTH(2), .DISTANCE_WIDTH(10), .WINDOW(5), .CNT_WIDTH(4)
  ) dut2 (
    .Clk_CI(clk), .Reset_RI(rst), .Flush_SI(flush), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one sample into dut (V stream fixed at label 1, distance 7) and returns just after the accept edge.
  task automatic send(input logic la, input logic [9:0] da);
    int unsigned n = 0;
    bus.LabelIn_A_DI    = la;
    bus.DistanceIn_A_DI = da;
    bus.LabelIn_V_DI    = 1'b1;
    bus.DistanceIn_V_DI = 10'd7;
    bus.ValidIn_SI      = 1'b1;
    #1;
    while (bus.ReadyOut_SO !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.ReadyOut_SO !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send_ready_timeout: ReadyOut_SO=%b required 1", bus.ReadyOut_SO);
    end
    tick();
    bus.ValidIn_SI = 1'b0;
  endtask

  task automatic send2(input logic [1:0] la, input logic [9:0] da);
    int unsigned n = 0;
    bus2.LabelIn_A_DI    = la;
    bus2.DistanceIn_A_DI = da;
    bus2.LabelIn_V_DI    = 2'd0;
    bus2.DistanceIn_V_DI = 10'd0;
    bus2.ValidIn_SI      = 1'b1;
    #1;
    while (bus2.ReadyOut_SO !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus2.ReadyOut_SO !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send2_ready_timeout: ReadyOut_SO=%b required 1", bus2.ReadyOut_SO);
    end
    tick();
    bus2.ValidIn_SI = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (bus.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", bus.ValidOut_SO); end
    tests++;
    if (bus.ReadyOut_SO !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", bus.ReadyOut_SO); end
    tests++;
    if (bus.LabelOut_A_DO !== 1'b0 || bus.LabelOut_V_DO !== 1'b0) begin
      fails++; $display("FAIL reset_labels: got A=%b V=%b exp 0/0", bus.LabelOut_A_DO, bus.LabelOut_V_DO);
    end
    tests++;
    if (bus.DistSumOut_A_DO !== 14'd0 || bus.DistSumOut_V_DO !== 14'd0) begin
      fails++; $display("FAIL reset_sums: got A=%0d V=%0d exp 0/0", bus.DistSumOut_A_DO, bus.DistSumOut_V_DO);
    end
    tests++;
    if (bus2.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL reset_valid2: got %b exp 0", bus2.ValidOut_SO); end
  endtask

  task automatic test_fill();
    logic la [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(la[i], 10'd100);
      tick();
      tests++;
      if (bus.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL fill_no_output[%0d]: got %b exp 0", i, bus.ValidOut_SO); end
    end
    send(la[4], 10'd100);
    tests++;
    if (bus.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL fill_latency: got %b exp 0", bus.ValidOut_SO); end
    tick();
    tests++;
    if (bus.ValidOut_SO !== 1'b1) begin fails++; $display("FAIL fill_valid: got %b exp 1", bus.ValidOut_SO); end
    tests++;
    if (bus.LabelOut_A_DO !== 1'b1 || bus.DistSumOut_A_DO !== 14'd500) begin
      fails++; $display("FAIL fill_A: got lab=%b sum=%0d exp 1/500", bus.LabelOut_A_DO, bus.DistSumOut_A_DO);
    end
    tests++;
    if (bus.LabelOut_V_DO !== 1'b1 || bus.DistSumOut_V_DO !== 14'd35) begin
      fails++; $display("FAIL fill_V: got lab=%b sum=%0d exp 1/35", bus.LabelOut_V_DO, bus.DistSumOut_V_DO);
    end
  endtask

  task automatic test_steady();
    logic       la   [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] da   [3] = '{10'd40, 10'd40, 10'd1};
    logic       elab [3] = '{1'b0, 1'b0, 1'b0};
    int         esum [3] = '{440, 380, 281};
    for (int i = 0; i < 3; i++) begin
      send(la[i], da[i]);
      tick();
      tests++;
      if (bus.ValidOut_SO !== 1'b1 || bus.LabelOut_A_DO !== elab[i] || bus.DistSumOut_A_DO !== 14'(esum[i])) begin
        fails++;
        $display("FAIL steady_A[%0d]: got v=%b lab=%b sum=%0d exp 1/%b/%0d",
                 i, bus.ValidOut_SO, bus.LabelOut_A_DO, bus.DistSumOut_A_DO, elab[i], esum[i]);
      end
      tests++;
      if (bus.LabelOut_V_DO !== 1'b1 || bus.DistSumOut_V_DO !== 14'd35) begin
        fails++; $display("FAIL steady_V[%0d]: got lab=%b sum=%0d exp 1/35", i, bus.LabelOut_V_DO, bus.DistSumOut_V_DO);
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned bad = 0;
    tick();
    bus.ReadyIn_SI = 1'b0;
    send(1'b1, 10'd2);
    tick();
    tests++;
    if (bus.ValidOut_SO !== 1'b1 || bus.LabelOut_A_DO !== 1'b0 || bus.DistSumOut_A_DO !== 14'd183) begin
      fails++;
      $display("FAIL bp_result: got v=%b lab=%b sum=%0d exp 1/0/183", bus.ValidOut_SO, bus.LabelOut_A_DO, bus.DistSumOut_A_DO);
    end
    bus.LabelIn_A_DI    = 1'b1;
    bus.DistanceIn_A_DI = 10'd3;
    bus.ValidIn_SI      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.ReadyOut_SO !== 1'b0 || bus.ValidOut_SO !== 1'b1 ||
          bus.LabelOut_A_DO !== 1'b0 || bus.DistSumOut_A_DO !== 14'd183) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL bp_hold: %0d unstable cycles, exp 0", bad); end
    bus.ReadyIn_SI = 1'b1;
    #1;
    tests++;
    if (bus.ReadyOut_SO !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b exp 1", bus.ReadyOut_SO); end
    tick();
    bus.ValidIn_SI = 1'b0;
    tests++;
    if (bus.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL bp_consumed: got %b exp 0", bus.ValidOut_SO); end
    tick();
    tests++;
    if (bus.ValidOut_SO !== 1'b1 || bus.LabelOut_A_DO !== 1'b1 || bus.DistSumOut_A_DO !== 14'd86) begin
      fails++;
      $display("FAIL bp_next: got v=%b lab=%b sum=%0d exp 1/1/86", bus.ValidOut_SO, bus.LabelOut_A_DO, bus.DistSumOut_A_DO);
    end
  endtask

  task automatic test_flush();
    logic       la [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [9:0] da [5] = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50};
    tick();
    flush               = 1'b1;
    bus.LabelIn_A_DI    = 1'b0;
    bus.DistanceIn_A_DI = 10'd999;
    bus.ValidIn_SI      = 1'b1;
    #1;
    tests++;
    if (bus.ReadyOut_SO !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b exp 0", bus.ReadyOut_SO); end
    tick();
    flush          = 1'b0;
    bus.ValidIn_SI = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(la[i], da[i]);
      tick();
      tests++;
      if (bus.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL flush_refill[%0d]: got %b exp 0", i, bus.ValidOut_SO); end
    end
    send(la[4], da[4]);
    tick();
    tests++;
    if (bus.ValidOut_SO !== 1'b1 || bus.LabelOut_A_DO !== 1'b1 || bus.DistSumOut_A_DO !== 14'd150) begin
      fails++;
      $display("FAIL flush_result: got v=%b lab=%b sum=%0d exp 1/1/150", bus.ValidOut_SO, bus.LabelOut_A_DO, bus.DistSumOut_A_DO);
    end
  endtask

  task automatic test_tie();
    logic [1:0] la [6] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3};
    for (int i = 0; i < 4; i++) begin
      send2(la[i], 10'(i + 1));
    end
    tick();
    tests++;
    if (bus2.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL tie_fill: got %b exp 0", bus2.ValidOut_SO); end
    send2(la[4], 10'd5);
    tick();
    tests++;
    if (bus2.ValidOut_SO !== 1'b1 || bus2.LabelOut_A_DO !== 2'd2 || bus2.DistSumOut_A_DO !== 14'd15) begin
      fails++;
      $display("FAIL tie_lowest: got v=%b lab=%0d sum=%0d exp 1/2/15", bus2.ValidOut_SO, bus2.LabelOut_A_DO, bus2.DistSumOut_A_DO);
    end
    send2(la[5], 10'd6);
    tick();
    tests++;
    if (bus2.LabelOut_A_DO !== 2'd3 || bus2.DistSumOut_A_DO !== 14'd20) begin
      fails++; $display("FAIL tie_evict: got lab=%0d sum=%0d exp 3/20", bus2.LabelOut_A_DO, bus2.DistSumOut_A_DO);
    end
  endtask

  task automatic test_reset_pending();
    send(1'b0, 10'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (bus.ValidOut_SO !== 1'b0 || bus.DistSumOut_A_DO !== 14'd0 || bus.DistSumOut_V_DO !== 14'd0) begin
      fails++;
      $display("FAIL rstpend_clear: got v=%b sumA=%0d sumV=%0d exp 0/0/0", bus.ValidOut_SO, bus.DistSumOut_A_DO, bus.DistSumOut_V_DO);
    end
    tick();
    tests++;
    if (bus.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL rstpend_novote: got %b exp 0", bus.ValidOut_SO); end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 10'd5);
      tick();
      tests++;
      if (bus.ValidOut_SO !== 1'b0) begin fails++; $display("FAIL rstpend_refill[%0d]: got %b exp 0", i, bus.ValidOut_SO); end
    end
    send(1'b1, 10'd5);
    tick();
    tests++;
    if (bus.ValidOut_SO !== 1'b1 || bus.LabelOut_A_DO !== 1'b1 || bus.DistSumOut_A_DO !== 14'd25 ||
        bus.DistSumOut_V_DO !== 14'd35) begin
      fails++;
      $display("FAIL rstpend_result: got v=%b lab=%b sumA=%0d sumV=%0d exp 1/1/25/35",
               bus.ValidOut_SO, bus.LabelOut_A_DO, bus.DistSumOut_A_DO, bus.DistSumOut_V_DO);
    end
  endtask

  initial begin
    tests                = 0;
    fails                = 0;
    rst                  = 1'b1;
    flush                = 1'b0;
    bus.ValidIn_SI       = 1'b0;
    bus.ReadyIn_SI       = 1'b1;
    bus.LabelIn_A_DI     = '0;
    bus.LabelIn_V_DI     = '0;
    bus.DistanceIn_A_DI  = '0;
    bus.DistanceIn_V_DI  = '0;
    bus2.ValidIn_SI      = 1'b0;
    bus2.ReadyIn_SI      = 1'b1;
    bus2.LabelIn_A_DI    = '0;
    bus2.LabelIn_V_DI    = '0;
    bus2.DistanceIn_A_DI = '0;
    bus2.DistanceIn_V_DI = '0;

    test_reset();
    test_fill();
    test_steady();
    test_backpressure();
    test_flush();
    test_tie();
    test_reset_pending();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
